mux_arbiter: RTL
================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter W, default 8: data width of each requester and of the output.
REQ-002 Parameter HOLD_MAX, default 4: maximum consecutive grant cycles for one requester while the other waits (timeout build only).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_a  input  1  requester A wants the mux; held high for the whole transfer.
REQ-006 req_b  input  1  requester B wants the mux; held high for the whole transfer.
REQ-007 a  input  W  requester A data.
REQ-008 b  input  W  requester B data.
REQ-009 gnt_a  output  1  A owns the mux; registered.
REQ-010 gnt_b  output  1  B owns the mux; registered.
REQ-011 s  output  1  mux select: 1 = b, 0 = a; registered.
REQ-012 f  output  W  selected data, s ? b : a, forced to 0 when v = 0; combinational from s/v/a/b.
REQ-013 v  output  1  f is valid, equal to gnt_a | gnt_b.

Function
REQ-014 FSM states: IDLE, GNT_A, GNT_B; gnt_a = (GNT_A), gnt_b = (GNT_B), s = (GNT_B).
REQ-015 Grant latency: a request sampled high at edge k shall produce its grant after edge k, with no earlier combinational grant.
REQ-016 IDLE: only req_a -> GNT_A; only req_b -> GNT_B; neither -> stay in IDLE.
REQ-017 IDLE with both requests -> grant the requester not named by register last (round-robin); last is updated on every grant.
REQ-018 GNT_A with req_a low -> GNT_B if req_b is high, else IDLE; there shall be no bubble cycle between back-to-back owners. GNT_B is symmetric.
REQ-019 Simultaneous release by the owner and a new request from the other requester in the same cycle -> hand over at that edge.
REQ-020 gnt_a and gnt_b shall never both be 1.
REQ-021 Hold counter cnt, width clog2(HOLD_MAX)+1: cleared on every grant change, incremented each cycle in GNT_A/GNT_B, saturating at HOLD_MAX-1.
REQ-022 A requester reasserting its request in the cycle after release shall be treated as a new request subject to round-robin.

Reset
REQ-023 rst high shall immediately force state IDLE, gnt_a = gnt_b = 0, s = 0, v = 0, f = 0, cnt = 0, last = B, so A wins the first contention.
REQ-024 Reset asserted mid-grant shall drop the grant asynchronously; the first grant after release follows REQ-016/017.

Configuration
REQ-025 Macro MUX_ARB_TIMEOUT_EN defined: in GNT_x with cnt == HOLD_MAX-1 and the other request high, the arbiter shall switch to the other requester at the next edge even if the owner still requests.
REQ-026 With the timeout feature, if the other requester is idle at timeout, the owner keeps the grant and cnt stays saturated.
REQ-027 MUX_ARB_TIMEOUT_EN undefined: cnt and HOLD_MAX logic shall be absent; a grant ends only on release of its request.

Structure
REQ-028 Package mux_arb_pkg shall hold the state enum (IDLE/GNT_A/GNT_B), the requester-id type for last, and the default W/HOLD_MAX constants.
REQ-029 Hold counter shall be a sub-module mux_arb_hold_cnt (clear, enable, saturate, at_max), instantiated only under MUX_ARB_TIMEOUT_EN.

Verification (W = 8, HOLD_MAX = 4)
REQ-030 Reset, a = 8'h5A, b = 8'hA5, no requests -> v = 0, f = 8'h00, s = 0 after any number of cycles.
REQ-031 req_a only for 3 cycles -> gnt_a one edge later, f = 8'h5A, v = 1 for 3 cycles, then IDLE with f = 0.
REQ-032 req_a and req_b rise together after reset -> GNT_A first; A releases -> GNT_B next edge with s = 1, f = 8'hA5, no bubble; next contention -> A.
REQ-033 MUX_ARB_TIMEOUT_EN defined, both held high continuously -> grants alternate every 4 cycles (A4, B4, A4...); undefined -> A holds indefinitely.
REQ-034 rst pulsed mid-GNT_B -> gnt_b, s, v, f go to 0 without waiting for clk; after release with both requests -> GNT_A.
REQ-035 Every run: assertion that gnt_a & gnt_b is never 1 and v == (gnt_a | gnt_b).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester mux arbiter.
package mux_arb_pkg;

    localparam int unsigned DefaultW       = 8;
    localparam int unsigned DefaultHoldMax = 4;

    typedef enum logic [1:0] {
        IDLE,
        GNT_A,
        GNT_B
    } arb_state_e;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_e;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold counter: counts consecutive owned cycles, flags the last allowed one.
module mux_arb_hold_cnt #(
    parameter int unsigned HOLD_MAX = mux_arb_pkg::DefaultHoldMax
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam int unsigned CntW = $clog2(HOLD_MAX) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HOLD_MAX - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CntMax);

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin two-requester mux arbiter with registered grants.
// Define MUX_ARB_TIMEOUT_EN to force a hand-over after HOLD_MAX cycles under contention.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned W        = DefaultW,
    parameter int unsigned HOLD_MAX = DefaultHoldMax
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         s,
    output logic [W-1:0] f,
    output logic         v
);

    arb_state_e state_q, state_d;
    req_id_e    last_q, last_d;

`ifdef MUX_ARB_TIMEOUT_EN
    logic at_max;

    mux_arb_hold_cnt #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_d != state_q),
        .en     (state_q != IDLE),
        .at_max (at_max)
    );
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_q == REQ_A) ? GNT_B : GNT_A;
                end else if (req_a) begin
                    state_d = GNT_A;
                end else if (req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                // Release hands straight to a waiting B, no idle bubble.
                if (!req_a) begin
                    state_d = req_b ? GNT_B : IDLE;
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (req_b && at_max) begin
                    state_d = GNT_B;
                end
`endif
            end
            GNT_B: begin
                if (!req_b) begin
                    state_d = req_a ? GNT_A : IDLE;
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (req_a && at_max) begin
                    state_d = GNT_A;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GNT_A && state_q != GNT_A) begin
            last_d = REQ_A;
        end else if (state_d == GNT_B && state_q != GNT_B) begin
            last_d = REQ_B;
        end
    end

    // last resets to B so A wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ_B;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        gnt_a = (state_q == GNT_A);
        gnt_b = (state_q == GNT_B);
        s     = gnt_b;
        v     = gnt_a | gnt_b;
        f     = v ? (s ? b : a) : '0;
    end

endmodule
